// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared encodings for the mcu execution sequencer
package mcu_pkg;

  localparam int DATA_W  = 8;
  localparam int FLAG_W  = 4;
  localparam int INSTR_W = 16;

  localparam logic [3:0] CLS_NOP  = 4'h0;
  localparam logic [3:0] CLS_ALUR = 4'h1;
  localparam logic [3:0] CLS_ALUI = 4'h2;
  localparam logic [3:0] CLS_ALUW = 4'h3;
  localparam logic [3:0] CLS_MOVR = 4'h4;
  localparam logic [3:0] CLS_JMP  = 4'h5;
  localparam logic [3:0] CLS_JCC  = 4'h6;
  localparam logic [3:0] CLS_HALT = 4'h7;

  // Mode presented to the ALU for every class that does not use it
  localparam logic [3:0] MODE_NONE = 4'h0;

  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_S = 1;
  localparam int FLG_O = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam int N_CARRY_MODES = 6;
  localparam logic [3:0] CARRY_MODES [N_CARRY_MODES] = '{4'h0, 4'h1, 4'h7, 4'h8, 4'h9, 4'hF};

  // Only arithmetic/shift modes produce a meaningful carry; all others keep C
  function automatic logic mode_updates_carry(input logic [3:0] mode);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_CARRY_MODES; i++) begin
      if (mode == CARRY_MODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic is_alu_class(input logic [3:0] cls);
    return (cls == CLS_ALUR) || (cls == CLS_ALUI) || (cls == CLS_ALUW);
  endfunction

endpackage

// File: rtl/mcu_regfile.sv
// rtl/mcu_regfile.sv - general register file, one write port, one async read port
module mcu_regfile
  import mcu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(NREGS)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/mcu_exec_ctrl.sv
// rtl/mcu_exec_ctrl.sv - fetch/decode/execute sequencer driving the 8-bit ALU
module mcu_exec_ctrl
  import mcu_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int NREGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Run,
  output logic [PC_W-1:0]   PM_Addr,
  input  logic [INSTR_W-1:0] PM_Data,
  output logic [3:0]        Mode,
  output logic [DATA_W-1:0] Operand1,
  output logic [DATA_W-1:0] Operand2,
  output logic              E,
  input  logic [DATA_W-1:0] ALU_Out,
  input  logic [FLAG_W-1:0] ALU_Flags,
  output logic [FLAG_W-1:0] CFlags,
  output logic [DATA_W-1:0] Acc,
  output logic              Halted,
  output logic              Illegal
);

  localparam int IDX_W = $clog2(NREGS);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]  op1_q, op1_d;
  logic [DATA_W-1:0]  op2_q, op2_d;
  logic [3:0]         mode_q, mode_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic [FLAG_W-1:0]  flags_commit;

  logic [3:0]         dec_cls;
  logic [3:0]         ex_cls;
  logic               jcc_taken;
  logic               illegal_c;
  logic               rf_we;
  logic [DATA_W-1:0]  rf_wdata;
  logic [DATA_W-1:0]  rf_rdata;

  assign dec_cls   = PM_Data[15:12];
  assign ex_cls    = ir_q[15:12];
  assign jcc_taken = flags_q[ir_q[9:8]] ^ ir_q[10];

  // Read port is addressed straight from PM_Data so operands latch in DECODE;
  // an ALUW write at the end of EXEC is therefore visible to the next DECODE.
  mcu_regfile #(
    .NREGS(NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we_i   (rf_we),
    .waddr_i(ir_q[IDX_W-1:0]),
    .wdata_i(rf_wdata),
    .raddr_i(PM_Data[IDX_W-1:0]),
    .rdata_o(rf_rdata)
  );

  always_comb begin
    flags_commit = ALU_Flags;
    if (!mode_updates_carry(mode_q)) flags_commit[FLG_C] = flags_q[FLG_C];
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    mode_d    = mode_q;
    flags_d   = flags_q;
    rf_we     = 1'b0;
    rf_wdata  = ALU_Out;
    illegal_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d = PM_Data;
        if (is_alu_class(dec_cls)) begin
          mode_d = PM_Data[11:8];
          op1_d  = acc_q;
          op2_d  = (dec_cls == CLS_ALUI) ? PM_Data[7:0] : rf_rdata;
        end else begin
          mode_d = MODE_NONE;
          op1_d  = '0;
          op2_d  = '0;
        end
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = Run ? ST_FETCH : ST_IDLE;
        case (ex_cls)
          CLS_NOP: ;
          CLS_ALUR, CLS_ALUI: begin
            acc_d   = ALU_Out;
            flags_d = flags_commit;
          end
          CLS_ALUW: begin
            rf_we   = 1'b1;
            flags_d = flags_commit;
          end
          CLS_MOVR: begin
            rf_we    = 1'b1;
            rf_wdata = acc_q;
          end
          CLS_JMP: pc_d = PC_W'(ir_q[7:0]);
          CLS_JCC: begin
            if (jcc_taken) pc_d = PC_W'(ir_q[7:0]);
          end
          CLS_HALT: state_d = ST_HALT;
          default: illegal_c = 1'b1;
        endcase
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      mode_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      mode_q  <= mode_d;
      flags_q <= flags_d;
    end
  end

  assign PM_Addr  = pc_q;
  assign Mode     = mode_q;
  assign Operand1 = op1_q;
  assign Operand2 = op2_q;
  assign E        = (state_q == ST_EXEC);
  assign CFlags   = flags_q;
  assign Acc      = acc_q;
  assign Halted   = (state_q == ST_HALT);
  assign Illegal  = illegal_c;

endmodule

// File: tb/tb_mcu_exec_ctrl.sv
// tb/tb_mcu_exec_ctrl.sv - scoreboard bench for the mcu execution sequencer
module tb_mcu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Run = 1'b0;
  logic [7:0]  PM_Addr;
  logic [15:0] PM_Data;
  logic [3:0]  Mode;
  logic [7:0]  Operand1, Operand2;
  logic        E;
  logic [7:0]  ALU_Out;
  logic [3:0]  ALU_Flags;
  logic [3:0]  CFlags;
  logic [7:0]  Acc;
  logic        Halted, Illegal;

  int checks = 0;
  int errors = 0;

  logic [15:0] pmem [256];

  typedef struct {
    bit         alu;
    logic [3:0] mode;
    logic [7:0] op1;
    logic [7:0] op2;
    logic       ill;
    logic [7:0] acc;
    logic [3:0] flg;
    logic [7:0] pc;
  } exp_t;

  exp_t sb_q[$];

  mcu_exec_ctrl #(.PC_W(8), .NREGS(16)) dut (
    .clk(clk), .rst(rst), .Run(Run), .PM_Addr(PM_Addr), .PM_Data(PM_Data),
    .Mode(Mode), .Operand1(Operand1), .Operand2(Operand2), .E(E),
    .ALU_Out(ALU_Out), .ALU_Flags(ALU_Flags), .CFlags(CFlags), .Acc(Acc),
    .Halted(Halted), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) PM_Data <= pmem[PM_Addr];

  // Stand-in ALU: 0 add, 1 sub (C = borrow), 4 and (reports C=0, O=msb), others pass Operand2
  logic [7:0] alu_res;
  logic       alu_c, alu_o;
  always_comb begin
    alu_res = Operand2;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (Mode)
      4'h0: begin
        {alu_c, alu_res} = {1'b0, Operand1} + {1'b0, Operand2};
        alu_o = (Operand1[7] == Operand2[7]) && (alu_res[7] != Operand1[7]);
      end
      4'h1: begin
        {alu_c, alu_res} = {1'b0, Operand1} - {1'b0, Operand2};
        alu_o = (Operand1[7] != Operand2[7]) && (alu_res[7] != Operand1[7]);
      end
      4'h4: begin
        alu_res = Operand1 & Operand2;
        alu_o   = alu_res[7];
      end
      default: ;
    endcase
  end
  assign ALU_Out   = alu_res;
  assign ALU_Flags = {(alu_res == 8'h00), alu_c, alu_res[7], alu_o};

  function automatic exp_t mk(bit alu, logic [3:0] mode, logic [7:0] op1, logic [7:0] op2,
                              logic ill, logic [7:0] acc, logic [3:0] flg, logic [7:0] pc);
    exp_t x;
    x.alu = alu; x.mode = mode; x.op1 = op1; x.op2 = op2;
    x.ill = ill; x.acc = acc; x.flg = flg; x.pc = pc;
    return x;
  endfunction

  // EXEC-phase outputs are captured, then compared with commit results one cycle later
  logic       pend = 1'b0;
  logic [3:0] m_mode;
  logic [7:0] m_op1, m_op2;
  logic       m_ill;
  exp_t       mx;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else if (pend) begin
      pend = 1'b0;
      if (sb_q.size() > 0) begin
        mx = sb_q.pop_front();
        checks++;
        if (m_mode !== mx.mode || (mx.alu && (m_op1 !== mx.op1 || m_op2 !== mx.op2))) begin
          errors++;
          $display("FAIL sb_operands: mode=%h op1=%h op2=%h, expected mode=%h op1=%h op2=%h",
                   m_mode, m_op1, m_op2, mx.mode, mx.op1, mx.op2);
        end
        checks++;
        if (m_ill !== mx.ill) begin
          errors++;
          $display("FAIL sb_illegal: got %b expected %b", m_ill, mx.ill);
        end
        checks++;
        if (Acc !== mx.acc || CFlags !== mx.flg || PM_Addr !== mx.pc) begin
          errors++;
          $display("FAIL sb_commit: acc=%h flags=%b pc=%h, expected acc=%h flags=%b pc=%h",
                   Acc, CFlags, PM_Addr, mx.acc, mx.flg, mx.pc);
        end
      end
    end
    if (!rst && E === 1'b1) begin
      m_mode = Mode; m_op1 = Operand1; m_op2 = Operand2; m_ill = Illegal;
      pend = 1'b1;
    end
  end

  task automatic do_reset();
    Run = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    for (int a = 0; a < 256; a++) pmem[a] = 16'h7000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (sb_q.size() == 0 && !pend) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_e(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (E === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    Run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({PM_Addr, Mode, Operand1, Operand2, E, CFlags, Acc, Halted, Illegal} !== 43'h0) begin
      errors++;
      $display("FAIL reset_outputs: pc=%h mode=%h op1=%h op2=%h e=%b flags=%b acc=%h halted=%b ill=%b, expected all zero",
               PM_Addr, Mode, Operand1, Operand2, E, CFlags, Acc, Halted, Illegal);
    end
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (E !== 1'b0 || PM_Addr !== 8'h00 || Halted !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle: %0d active cycles with Run=0, expected 0", bad);
    end
  endtask

  task automatic test_alui();
    int first_e, second_e;
    bit ok;
    do_reset();
    pmem[0] = 16'h2005;
    pmem[1] = 16'h20FB;
    sb_q.push_back(mk(1, 4'h0, 8'h00, 8'h05, 1'b0, 8'h05, 4'b0000, 8'h01));
    sb_q.push_back(mk(1, 4'h0, 8'h05, 8'hFB, 1'b0, 8'h00, 4'b1100, 8'h02));
    first_e = -1;
    second_e = -1;
    Run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (E === 1'b1) begin
        if (first_e < 0) first_e = c;
        else if (second_e < 0) second_e = c;
      end
    end
    checks++;
    if (first_e != 3 || second_e != 6) begin
      errors++;
      $display("FAIL alui_timing: EXEC at cycles %0d,%0d, expected 3,6", first_e, second_e);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL alui_drain: %0d results outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_aluw();
    bit ok;
    do_reset();
    pmem[0] = 16'h20F8;
    pmem[1] = 16'h20F8;
    pmem[2] = 16'h4003;
    pmem[3] = 16'h3403;
    pmem[4] = 16'h2110;
    pmem[5] = 16'h3003;
    pmem[6] = 16'h1503;
    sb_q.push_back(mk(1, 4'h0, 8'h00, 8'hF8, 1'b0, 8'hF8, 4'b0010, 8'h01));
    sb_q.push_back(mk(1, 4'h0, 8'hF8, 8'hF8, 1'b0, 8'hF0, 4'b0110, 8'h02));
    sb_q.push_back(mk(0, 4'h0, 8'h00, 8'h00, 1'b0, 8'hF0, 4'b0110, 8'h03));
    sb_q.push_back(mk(1, 4'h4, 8'hF0, 8'hF0, 1'b0, 8'hF0, 4'b0111, 8'h04));
    sb_q.push_back(mk(1, 4'h1, 8'hF0, 8'h10, 1'b0, 8'hE0, 4'b0010, 8'h05));
    sb_q.push_back(mk(1, 4'h0, 8'hE0, 8'hF0, 1'b0, 8'hE0, 4'b0110, 8'h06));
    sb_q.push_back(mk(1, 4'h5, 8'hE0, 8'hD0, 1'b0, 8'hD0, 4'b0110, 8'h07));
    Run = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL aluw_drain: %0d results outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_jcc();
    bit ok;
    do_reset();
    pmem[8'h00] = 16'h2005;
    pmem[8'h01] = 16'h2105;
    pmem[8'h02] = 16'h6340;
    pmem[8'h40] = 16'h6780;
    pmem[8'h41] = 16'h6290;
    pmem[8'h42] = 16'h6690;
    sb_q.push_back(mk(1, 4'h0, 8'h00, 8'h05, 1'b0, 8'h05, 4'b0000, 8'h01));
    sb_q.push_back(mk(1, 4'h1, 8'h05, 8'h05, 1'b0, 8'h00, 4'b1000, 8'h02));
    sb_q.push_back(mk(0, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 4'b1000, 8'h40));
    sb_q.push_back(mk(0, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 4'b1000, 8'h41));
    sb_q.push_back(mk(0, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 4'b1000, 8'h42));
    sb_q.push_back(mk(0, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 4'b1000, 8'h90));
    Run = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL jcc_drain: %0d results outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_jmp_wrap();
    bit ok;
    do_reset();
    pmem[8'h00] = 16'h50FF;
    pmem[8'hFF] = 16'h0000;
    sb_q.push_back(mk(0, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0000, 8'hFF));
    sb_q.push_back(mk(0, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0000, 8'h00));
    sb_q.push_back(mk(0, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0000, 8'hFF));
    Run = 1'b1;
    wait_drain(ok);
    Run = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL jmp_wrap_drain: %0d results outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_run_drop();
    int e_cnt;
    bit ok;
    do_reset();
    for (int a = 0; a < 8; a++) pmem[a] = 16'h0000;
    sb_q.push_back(mk(0, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0000, 8'h01));
    sb_q.push_back(mk(0, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0000, 8'h02));
    Run = 1'b1;
    wait_e(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL run_drop_start: E never asserted, expected EXEC");
    end
    @(negedge clk);
    @(negedge clk);
    Run = 1'b0;
    e_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (E === 1'b1) e_cnt++;
    end
    checks++;
    if (e_cnt != 1) begin
      errors++;
      $display("FAIL run_drop_exec: %0d EXEC cycles after Run fell, expected 1", e_cnt);
    end
    checks++;
    if (PM_Addr !== 8'h02 || E !== 1'b0 || Halted !== 1'b0) begin
      errors++;
      $display("FAIL run_drop_park: pc=%h e=%b halted=%b, expected pc=02 e=0 halted=0", PM_Addr, E, Halted);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL run_drop_drain: %0d results outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_illegal_halt();
    int ill_cnt, hold;
    bit halted_seen, ok;
    do_reset();
    pmem[0] = 16'h2022;
    pmem[1] = 16'hA123;
    sb_q.push_back(mk(1, 4'h0, 8'h00, 8'h22, 1'b0, 8'h22, 4'b0000, 8'h01));
    sb_q.push_back(mk(0, 4'h0, 8'h00, 8'h00, 1'b1, 8'h22, 4'b0000, 8'h02));
    Run = 1'b1;
    ill_cnt = 0;
    halted_seen = 1'b0;
    for (int c = 0; c < 60 && !halted_seen; c++) begin
      @(negedge clk);
      if (Illegal === 1'b1) ill_cnt++;
      if (Halted === 1'b1) halted_seen = 1'b1;
    end
    checks++;
    if (!halted_seen) begin
      errors++;
      $display("FAIL halt_reach: Halted=%b, expected 1", Halted);
    end
    checks++;
    if (ill_cnt != 1) begin
      errors++;
      $display("FAIL illegal_pulse: %0d cycles high, expected 1", ill_cnt);
    end
    hold = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (Halted === 1'b1 && E === 1'b0 && Illegal === 1'b0) hold++;
    end
    checks++;
    if (hold != 20) begin
      errors++;
      $display("FAIL halt_hold: %0d of 20 cycles halted, expected 20", hold);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL illegal_drain: %0d results outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    do_reset();
    pmem[0] = 16'h2033;
    Run = 1'b1;
    wait_e(ok);
    checks++;
    if (!ok || Operand2 !== 8'h33) begin
      errors++;
      $display("FAIL rst_exec_entry: e=%b op2=%h, expected e=1 op2=33", E, Operand2);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({PM_Addr, Mode, Operand1, Operand2, E, CFlags, Acc, Halted, Illegal} !== 43'h0) begin
      errors++;
      $display("FAIL rst_exec_abort: pc=%h mode=%h op1=%h op2=%h e=%b flags=%b acc=%h halted=%b ill=%b, expected all zero",
               PM_Addr, Mode, Operand1, Operand2, E, CFlags, Acc, Halted, Illegal);
    end
    @(negedge clk);
    @(negedge clk);
    Run = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (PM_Addr !== 8'h00 || Acc !== 8'h00 || E !== 1'b0 || CFlags !== 4'b0000) begin
      errors++;
      $display("FAIL rst_exec_release: pc=%h acc=%h e=%b flags=%b, expected pc=00 acc=00 e=0 flags=0000",
               PM_Addr, Acc, E, CFlags);
    end
  endtask

  initial begin
    test_reset();
    test_alui();
    test_aluw();
    test_jcc();
    test_jmp_wrap();
    test_run_drop();
    test_illegal_halt();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
